// File: rtl/vec_exec_pkg.sv
// Shared types and helpers for the vector integer execution unit.
// Op and state encodings, legal element widths and the log2(sew) helper.
package vec_exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_MINU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [6:0] SEW8  = 7'd8;
  localparam logic [6:0] SEW16 = 7'd16;
  localparam logic [6:0] SEW32 = 7'd32;
  localparam logic [6:0] SEW64 = 7'd64;

  function automatic logic [2:0] sew_log2(input logic [6:0] sew);
    logic [2:0] lg;
    case (sew)
      SEW16:   lg = 3'd4;
      SEW32:   lg = 3'd5;
      SEW64:   lg = 3'd6;
      default: lg = 3'd3;
    endcase
    return lg;
  endfunction

endpackage

// File: rtl/vec_simd_alu.sv
// One BEAT_W-wide SIMD slice: per-element op at 8/16/32/64-bit SEW, no carry across elements.
// Purely combinational; no handshake.
module vec_simd_alu
  import vec_exec_pkg::*;
#(
  parameter int BEAT_W = 64
) (
  input  op_e               op,
  input  logic [6:0]        sew,
  input  logic [BEAT_W-1:0] a,
  input  logic [BEAT_W-1:0] b,
  output logic [BEAT_W-1:0] y
);

  // Elements arrive zero-extended, so SRL stays logical and MINU unsigned; caller truncates.
  function automatic logic [63:0] elem_op(input op_e o, input logic [63:0] x,
                                          input logic [63:0] z, input logic [5:0] sh_mask);
    logic [5:0]  sh;
    logic [63:0] r;
    sh = z[5:0] & sh_mask;
    case (o)
      OP_ADD:  r = x + z;
      OP_SUB:  r = x - z;
      OP_AND:  r = x & z;
      OP_OR:   r = x | z;
      OP_XOR:  r = x ^ z;
      OP_SLL:  r = x << sh;
      OP_SRL:  r = x >> sh;
      default: r = (x < z) ? x : z;
    endcase
    return r;
  endfunction

  logic [63:0] t;
  logic [5:0]  sh_mask;

  always_comb begin
    y       = '0;
    t       = '0;
    sh_mask = 6'((7'd1 << sew_log2(sew)) - 7'd1);
    case (sew)
      SEW8: begin
        for (int j = 0; j < BEAT_W/8; j++) begin
          t = elem_op(op, 64'(a[j*8 +: 8]), 64'(b[j*8 +: 8]), sh_mask);
          y[j*8 +: 8] = t[7:0];
        end
      end
      SEW16: begin
        for (int j = 0; j < BEAT_W/16; j++) begin
          t = elem_op(op, 64'(a[j*16 +: 16]), 64'(b[j*16 +: 16]), sh_mask);
          y[j*16 +: 16] = t[15:0];
        end
      end
      SEW32: begin
        for (int j = 0; j < BEAT_W/32; j++) begin
          t = elem_op(op, 64'(a[j*32 +: 32]), 64'(b[j*32 +: 32]), sh_mask);
          y[j*32 +: 32] = t[31:0];
        end
      end
      SEW64: begin
        for (int j = 0; j < BEAT_W/64; j++) begin
          t = elem_op(op, a[j*64 +: 64], b[j*64 +: 64], sh_mask);
          y[j*64 +: 64] = t;
        end
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vec_exec_lanes.sv
// Multi-cycle vector integer unit: NBEATS beats per register group with v0 mask and tail merge.
// Latency NBEATS+1 cycles (illegal: 1); no backpressure, start is ignored outside IDLE.
module vec_exec_lanes
  import vec_exec_pkg::*;
#(
  parameter int MAX_VLEN = 512,
  parameter int BEAT_W   = 64,
  parameter int XLEN     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [6:0]            sew,
  input  logic [XLEN-1:0]       vl,
  input  logic                  vm,
  input  logic                  tail_agnostic,
  input  logic                  mask_agnostic,
  input  logic [MAX_VLEN/8-1:0] v0_mask,
  input  logic [MAX_VLEN-1:0]   operand_a,
  input  logic [MAX_VLEN-1:0]   operand_b,
  input  logic [MAX_VLEN-1:0]   dst_old,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic [MAX_VLEN-1:0]   result
);

  localparam int NBEATS     = MAX_VLEN / BEAT_W;
  localparam int MASK_W     = MAX_VLEN / 8;
  localparam int CNT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int IDX_W      = $clog2(MASK_W);
  localparam int BEAT_BYTES = BEAT_W / 8;

  function automatic logic req_legal(input logic [6:0] s, input logic [XLEN-1:0] n);
    logic ok;
    case (s)
      SEW8:    ok = (n <= XLEN'(MAX_VLEN / 8));
      SEW16:   ok = (n <= XLEN'(MAX_VLEN / 16));
      SEW32:   ok = (n <= XLEN'(MAX_VLEN / 32));
      SEW64:   ok = (n <= XLEN'(MAX_VLEN / 64));
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  op_e                   op_q, op_d;
  logic [6:0]            sew_q, sew_d;
  logic [XLEN-1:0]       vl_q, vl_d;
  logic                  vm_q, vm_d;
  logic                  ta_q, ta_d;
  logic                  ma_q, ma_d;
  logic [MASK_W-1:0]     v0_q, v0_d;
  logic [MAX_VLEN-1:0]   a_q, a_d;
  logic [MAX_VLEN-1:0]   b_q, b_d;
  logic [MAX_VLEN-1:0]   old_q, old_d;
  logic [MAX_VLEN-1:0]   result_q, result_d;
  logic                  illegal_q, illegal_d;

  logic [BEAT_W-1:0]     a_beat, b_beat, old_beat, alu_beat, merged_beat;
  logic [IDX_W-1:0]      byte_idx, elem_idx;
  logic                  is_tail, is_masked;

  always_comb begin
    a_beat   = '0;
    b_beat   = '0;
    old_beat = '0;
    for (int k = 0; k < NBEATS; k++) begin
      if (CNT_W'(k) == cnt_q) begin
        a_beat   = a_q[k*BEAT_W +: BEAT_W];
        b_beat   = b_q[k*BEAT_W +: BEAT_W];
        old_beat = old_q[k*BEAT_W +: BEAT_W];
      end
    end
  end

  vec_simd_alu #(.BEAT_W(BEAT_W)) u_alu (
    .op  (op_q),
    .sew (sew_q),
    .a   (a_beat),
    .b   (b_beat),
    .y   (alu_beat)
  );

  // Element index = global byte index >> log2(sew bytes); every byte of an element agrees.
  always_comb begin
    merged_beat = '0;
    byte_idx    = '0;
    elem_idx    = '0;
    is_tail     = 1'b0;
    is_masked   = 1'b0;
    for (int bb = 0; bb < BEAT_BYTES; bb++) begin
      byte_idx  = IDX_W'(cnt_q) * IDX_W'(BEAT_BYTES) + IDX_W'(bb);
      elem_idx  = byte_idx >> (sew_log2(sew_q) - 3'd3);
      is_tail   = ({{(XLEN-IDX_W){1'b0}}, elem_idx} >= vl_q);
      is_masked = !vm_q && !v0_q[elem_idx];
      if (is_tail) begin
        merged_beat[bb*8 +: 8] = ta_q ? 8'hFF : old_beat[bb*8 +: 8];
      end else if (is_masked) begin
        merged_beat[bb*8 +: 8] = ma_q ? 8'hFF : old_beat[bb*8 +: 8];
      end else begin
        merged_beat[bb*8 +: 8] = alu_beat[bb*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sew_d     = sew_q;
    vl_d      = vl_q;
    vm_d      = vm_q;
    ta_d      = ta_q;
    ma_d      = ma_q;
    v0_d      = v0_q;
    a_d       = a_q;
    b_d       = b_q;
    old_d     = old_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op_e'(op);
          sew_d = sew;
          vl_d  = vl;
          vm_d  = vm;
          ta_d  = tail_agnostic;
          ma_d  = mask_agnostic;
          v0_d  = v0_mask;
          a_d   = operand_a;
          b_d   = operand_b;
          old_d = dst_old;
          if (!req_legal(sew, vl)) begin
            illegal_d = 1'b1;
            result_d  = dst_old;
            state_d   = ST_DONE;
          end else begin
            illegal_d = 1'b0;
            cnt_d     = '0;
            state_d   = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        for (int k = 0; k < NBEATS; k++) begin
          if (CNT_W'(k) == cnt_q) result_d[k*BEAT_W +: BEAT_W] = merged_beat;
        end
        if (cnt_q == CNT_W'(NBEATS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_ADD;
      sew_q     <= SEW8;
      vl_q      <= '0;
      vm_q      <= 1'b1;
      ta_q      <= 1'b0;
      ma_q      <= 1'b0;
      v0_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      old_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sew_q     <= sew_d;
      vl_q      <= vl_d;
      vm_q      <= vm_d;
      ta_q      <= ta_d;
      ma_q      <= ma_d;
      v0_q      <= v0_d;
      a_q       <= a_d;
      b_q       <= b_d;
      old_q     <= old_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy    = (state_q == ST_EXEC);
  assign done    = (state_q == ST_DONE);
  assign illegal = illegal_q;
  assign result  = result_q;

endmodule

// File: tb/tb_vec_exec_lanes.sv
// Directed vector table plus hand-written handshake/reset sequences for vec_exec_lanes.
module tb_vec_exec_lanes;

  localparam int MV     = 512;
  localparam int NBEATS = 8;

  logic           clk = 1'b0;
  logic           reset, start, vm, tail_agnostic, mask_agnostic;
  logic [2:0]     op;
  logic [6:0]     sew;
  logic [31:0]    vl;
  logic [63:0]    v0_mask;
  logic [MV-1:0]  operand_a, operand_b, dst_old;
  logic           busy, done, illegal;
  logic [MV-1:0]  result;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vec_exec_lanes #(.MAX_VLEN(MV), .BEAT_W(64), .XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .sew           (sew),
    .vl            (vl),
    .vm            (vm),
    .tail_agnostic (tail_agnostic),
    .mask_agnostic (mask_agnostic),
    .v0_mask       (v0_mask),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .dst_old       (dst_old),
    .busy          (busy),
    .done          (done),
    .illegal       (illegal),
    .result        (result)
  );

  typedef struct {
    string         name;
    logic [2:0]    op;
    logic [6:0]    sew;
    logic [31:0]   vl;
    logic          vm, ta, ma;
    logic [63:0]   v0;
    logic [MV-1:0] a, b, old, exp;
    logic          exp_ill;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [MV-1:0] act, input logic [MV-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [2:0] o, input logic [6:0] s,
                         input logic [31:0] n, input logic m, input logic ta, input logic ma,
                         input logic [63:0] v0, input logic [MV-1:0] a, input logic [MV-1:0] b,
                         input logic [MV-1:0] old, input logic [MV-1:0] exp, input logic ill);
    vec_t v;
    v.name = name; v.op = o; v.sew = s; v.vl = n; v.vm = m; v.ta = ta; v.ma = ma;
    v.v0 = v0; v.a = a; v.b = b; v.old = old; v.exp = exp; v.exp_ill = ill;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    op = v.op; sew = v.sew; vl = v.vl; vm = v.vm;
    tail_agnostic = v.ta; mask_agnostic = v.ma; v0_mask = v.v0;
    operand_a = v.a; operand_b = v.b; dst_old = v.old;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the cycle following done.
  task automatic run_vec(input vec_t v);
    int cyc, busy_cnt, exp_cyc;
    drive(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = '1; operand_b = '1; dst_old = '0; vl = 32'd7;
    cyc = 1; busy_cnt = 0;
    while (!done && cyc <= 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    exp_cyc = v.exp_ill ? 1 : NBEATS + 1;
    chk($sformatf("%s.done_cycle", v.name), MV'(cyc), MV'(exp_cyc));
    chk($sformatf("%s.busy_cycles", v.name), MV'(busy_cnt), MV'(v.exp_ill ? 0 : NBEATS));
    chk($sformatf("%s.busy_at_done", v.name), MV'(busy), MV'(0));
    chk($sformatf("%s.illegal", v.name), MV'(illegal), MV'(v.exp_ill));
    chk($sformatf("%s.result", v.name), result, v.exp);
    @(posedge clk); #1;
    chk($sformatf("%s.done_width", v.name), MV'(done), MV'(0));
  endtask

  initial begin
    logic [63:0]   xa, xb, xo, xr;
    logic [MV-1:0] ones;
    int done_cnt, done_cyc, busy_late;
    vec_t v;

    ones = '1;
    xa = 64'hF0F0_1234_5678_9ABC;
    xb = 64'h0FF0_FFFF_0000_1111;
    xo = 64'hDEAD_BEEF_CAFE_F00D;
    xr = 64'hFF00_EDCB_5678_8BAD;

    add_vec("add8_wrap", 3'd0, 7'd8, 32'd64, 1'b1, 1'b0, 1'b0, 64'h0,
            {64{8'hFF}}, {64{8'h01}}, {16{32'h1234_5678}}, '0, 1'b0);
    add_vec("sub32_tu", 3'd1, 7'd32, 32'd5, 1'b1, 1'b0, 1'b0, 64'h0,
            {16{32'd10}}, {16{32'd3}}, {64{8'hA5}}, {{11{32'hA5A5_A5A5}}, {5{32'd7}}}, 1'b0);
    add_vec("sub32_ta", 3'd1, 7'd32, 32'd5, 1'b1, 1'b1, 1'b0, 64'h0,
            {16{32'd10}}, {16{32'd3}}, {64{8'hA5}}, {{11{32'hFFFF_FFFF}}, {5{32'd7}}}, 1'b0);
    add_vec("xor64_mu", 3'd4, 7'd64, 32'd4, 1'b0, 1'b0, 1'b0, 64'h5,
            {8{xa}}, {8{xb}}, {8{xo}}, {{4{xo}}, xo, xr, xo, xr}, 1'b0);
    add_vec("xor64_ma", 3'd4, 7'd64, 32'd4, 1'b0, 1'b0, 1'b1, 64'h5,
            {8{xa}}, {8{xb}}, {8{xo}}, {{4{xo}}, 64'hFFFF_FFFF_FFFF_FFFF, xr,
                                        64'hFFFF_FFFF_FFFF_FFFF, xr}, 1'b0);
    add_vec("ill_vl33", 3'd0, 7'd16, 32'd33, 1'b1, 1'b0, 1'b0, 64'h0,
            {32{16'h1111}}, {32{16'h2222}}, {16{32'hCAFE_0001}}, {16{32'hCAFE_0001}}, 1'b1);
    add_vec("ill_sew12", 3'd0, 7'd12, 32'd1, 1'b1, 1'b0, 1'b0, 64'h0,
            {32{16'h1111}}, {32{16'h2222}}, {16{32'h0BAD_F00D}}, {16{32'h0BAD_F00D}}, 1'b1);
    add_vec("ill_vl65", 3'd0, 7'd8, 32'd65, 1'b1, 1'b0, 1'b0, 64'h0,
            '0, '0, {16{32'h7777_0000}}, {16{32'h7777_0000}}, 1'b1);
    add_vec("sll16", 3'd5, 7'd16, 32'd32, 1'b1, 1'b0, 1'b0, 64'h0,
            {32{16'h0001}}, {32{16'h0013}}, {64{8'h5A}}, {32{16'h0008}}, 1'b0);
    add_vec("sll16_vl0", 3'd5, 7'd16, 32'd0, 1'b1, 1'b0, 1'b0, 64'h0,
            {32{16'h0001}}, {32{16'h0013}}, {64{8'h5A}}, {64{8'h5A}}, 1'b0);
    add_vec("minu8", 3'd7, 7'd8, 32'd64, 1'b1, 1'b0, 1'b0, 64'h0,
            {32{16'h0380}}, {64{8'h10}}, '0, {32{16'h0310}}, 1'b0);
    add_vec("srl32", 3'd6, 7'd32, 32'd16, 1'b1, 1'b0, 1'b0, 64'h0,
            {16{32'h8000_0000}}, {16{32'h0000_0024}}, '0, {16{32'h0800_0000}}, 1'b0);
    add_vec("and16", 3'd2, 7'd16, 32'd32, 1'b1, 1'b0, 1'b0, 64'h0,
            {32{16'hF0F0}}, {32{16'h3C3C}}, '0, {32{16'h3030}}, 1'b0);
    add_vec("or8", 3'd3, 7'd8, 32'd64, 1'b1, 1'b0, 1'b0, 64'h0,
            {64{8'hF0}}, {64{8'h0F}}, '0, ones, 1'b0);
    add_vec("add16_carry", 3'd0, 7'd16, 32'd32, 1'b1, 1'b0, 1'b0, 64'h0,
            {32{16'h00FF}}, {32{16'h0001}}, '0, {32{16'h0100}}, 1'b0);
    add_vec("add64_carry", 3'd0, 7'd64, 32'd8, 1'b1, 1'b0, 1'b0, 64'h0,
            {8{64'h0000_0000_FFFF_FFFF}}, {8{64'h1}}, '0, {8{64'h0000_0001_0000_0000}}, 1'b0);
    add_vec("sub8_borrow", 3'd1, 7'd8, 32'd64, 1'b1, 1'b0, 1'b0, 64'h0,
            '0, {64{8'h01}}, '0, ones, 1'b0);

    reset = 1'b1; start = 1'b0;
    drive(vq[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", MV'(busy), MV'(0));
    chk("reset.done", MV'(done), MV'(0));
    chk("reset.illegal", MV'(illegal), MV'(0));
    chk("reset.result", result, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);

    // start held through EXEC and DONE must not launch a second operation
    v = vq[1];
    drive(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = '1; dst_old = '0;
    done_cnt = 0; done_cyc = 0; busy_late = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c >= 10 && busy) busy_late++;
      start = (c >= 2 && c <= 9);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("restart.done_count", MV'(done_cnt), MV'(1));
    chk("restart.done_cycle", MV'(done_cyc), MV'(NBEATS + 1));
    chk("restart.no_relaunch", MV'(busy_late), MV'(0));
    chk("restart.result", result, v.exp);

    // reset in EXEC cycle 4 discards the operation
    drive(vq[0]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("midrst.busy_before", MV'(busy), MV'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.busy", MV'(busy), MV'(0));
    chk("midrst.result", result, '0);
    chk("midrst.illegal", MV'(illegal), MV'(0));
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (done || busy) done_cnt++;
      @(posedge clk); #1;
    end
    chk("midrst.no_done", MV'(done_cnt), MV'(0));

    run_vec(vq[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
